// File: rtl/dmux_8way_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmux_8way_pkg
// Description : Shared types and symbolic select codes for the registered
//               8-to-1 selector (dmux_8way) and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package dmux_8way_pkg;

  // Binary index into the eight data inputs A..H
  typedef logic [2:0] sel_t;

  // Symbolic select codes, one per data input
  localparam sel_t SEL_A = 3'd0;
  localparam sel_t SEL_B = 3'd1;
  localparam sel_t SEL_C = 3'd2;
  localparam sel_t SEL_D = 3'd3;
  localparam sel_t SEL_E = 3'd4;
  localparam sel_t SEL_F = 3'd5;
  localparam sel_t SEL_G = 3'd6;
  localparam sel_t SEL_H = 3'd7;

endpackage : dmux_8way_pkg
`default_nettype wire

// File: rtl/dmux_8way_sel.sv
`default_nettype none
// ============================================================================
// Module      : dmux_8way_sel
// Description : Purely combinational WIDTH-bit 8:1 selector. Every select
//               code maps to exactly one input; there is no error case.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_8way_sel
  import dmux_8way_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] e_i,
  input  logic [WIDTH-1:0] f_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] h_i,
  input  sel_t             sel_i,
  output logic [WIDTH-1:0] y_o
);

  // Steer the input addressed by sel_i to the output; default keeps it latch-free
  always_comb begin
    y_o = '0;
    case (sel_i)
      SEL_A: y_o = a_i;
      SEL_B: y_o = b_i;
      SEL_C: y_o = c_i;
      SEL_D: y_o = d_i;
      SEL_E: y_o = e_i;
      SEL_F: y_o = f_i;
      SEL_G: y_o = g_i;
      SEL_H: y_o = h_i;
      default: y_o = '0;
    endcase
  end

endmodule : dmux_8way_sel
`default_nettype wire

// File: rtl/dmux_8way.sv
`default_nettype none
// ============================================================================
// Module      : dmux_8way
// Description : Registered, enable-gated 8-to-1 selector. The input chosen
//               by SEL is captured on a rising CLK edge when EN is high and
//               appears on OUT one cycle later with VALID. OUT holds while
//               EN is low. RST_N clears OUT and VALID asynchronously.
//               (Many-to-one despite the historical "dmux" name.)
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_8way
  import dmux_8way_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [2:0]       SEL,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             valid_d;
  logic             valid_q;

  dmux_8way_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .a_i   (A),
    .b_i   (B),
    .c_i   (C),
    .d_i   (D),
    .e_i   (E),
    .f_i   (F),
    .g_i   (G),
    .h_i   (H),
    .sel_i (sel_t'(SEL)),
    .y_o   (sel_data)
  );

  // Next-state: load the selected data when enabled, otherwise hold; VALID mirrors EN
  always_comb begin
    out_d   = out_q;
    valid_d = EN;
    if (EN) begin
      out_d = sel_data;
    end
  end

  // Output registers with asynchronous active-low clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign OUT   = out_q;
  assign VALID = valid_q;

endmodule : dmux_8way
`default_nettype wire

// File: tb/tb_dmux_8way.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux_8way
// Description : Directed self-checking bench for dmux_8way. A WIDTH=1
//               instance covers reset and the exhaustive sweep; a WIDTH=8
//               instance covers isolation, enable hold and mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux_8way;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] sel;
  logic [7:0] d8 [8];
  logic [7:0] bits1;
  logic [7:0] out8;
  logic       v8;
  logic [0:0] out1;
  logic       v1;

  int errors = 0;
  int checks = 0;

  dmux_8way #(.WIDTH(8)) u_dut8 (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en),
    .A     (d8[0]),
    .B     (d8[1]),
    .C     (d8[2]),
    .D     (d8[3]),
    .E     (d8[4]),
    .F     (d8[5]),
    .G     (d8[6]),
    .H     (d8[7]),
    .SEL   (sel),
    .OUT   (out8),
    .VALID (v8)
  );

  dmux_8way #(.WIDTH(1)) u_dut1 (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en),
    .A     (bits1[0:0]),
    .B     (bits1[1:1]),
    .C     (bits1[2:2]),
    .D     (bits1[3:3]),
    .E     (bits1[4:4]),
    .F     (bits1[5:5]),
    .G     (bits1[6:6]),
    .H     (bits1[7:7]),
    .SEL   (sel),
    .OUT   (out1),
    .VALID (v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_d8_ramp();
    d8[0] = 8'h11; d8[1] = 8'h22; d8[2] = 8'h33; d8[3] = 8'h44;
    d8[4] = 8'h55; d8[5] = 8'h66; d8[6] = 8'h77; d8[7] = 8'h88;
  endtask

  // Expected value for the ramp pattern: input k holds 8'h11*(k+1)
  function automatic logic [7:0] ramp_exp(input logic [2:0] s);
    logic [7:0] r;
    r = 8'h11 * ({5'd0, s} + 8'd1);
    return r;
  endfunction

  initial begin
    logic [10:0] vec;
    logic [7:0]  exp1;
    int          idx;

    // ---------------- Reset: asynchronous clear before any clock edge
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 3'd0;
    bits1 = 8'hFF;
    for (int k = 0; k < 8; k++) d8[k] = 8'h01;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_async_out8",   out8, 8'h00);
    check_val("rst_async_valid8", {7'd0, v8}, 8'h00);
    check_val("rst_async_out1",   {7'd0, out1}, 8'h00);
    check_val("rst_async_valid1", {7'd0, v1}, 8'h00);
    // Held through clock edges while asserted
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_out8",   out8, 8'h00);
    check_val("rst_hold_valid8", {7'd0, v8}, 8'h00);
    // Release: first edge captures
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_rel_out8",   out8, 8'h01);
    check_val("rst_rel_valid8", {7'd0, v8}, 8'h01);
    check_val("rst_rel_out1",   {7'd0, out1}, 8'h01);
    check_val("rst_rel_valid1", {7'd0, v1}, 8'h01);

    // ---------------- Exhaustive sweep, WIDTH=1: {A..H,SEL} = i
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      vec = i[10:0];
      for (int k = 0; k < 8; k++) bits1[k] = vec[10-k];
      sel = vec[2:0];
      en  = 1'b1;
      @(posedge clk);
      #1;
      idx  = 10 - int'(vec[2:0]);
      exp1 = {7'd0, vec[idx]};
      check_val("sweep_out1", {7'd0, out1}, exp1);
      if (i % 256 == 0) check_val("sweep_valid1", {7'd0, v1}, 8'h01);
    end
    // Spot-check the two documented example vectors explicitly
    @(negedge clk);
    bits1 = 8'h01; sel = 3'd0;             // i = 11'b10000000_000
    @(posedge clk); #1;
    check_val("sweep_ex_a", {7'd0, out1}, 8'h01);
    @(negedge clk);
    sel = 3'd1;                            // i = 11'b10000000_001
    @(posedge clk); #1;
    check_val("sweep_ex_b", {7'd0, out1}, 8'h00);

    // ---------------- Isolation, WIDTH=8: SEL=5 picks F=8'h66
    @(negedge clk);
    set_d8_ramp();
    sel = 3'd5;
    en  = 1'b1;
    @(posedge clk); #1;
    check_val("iso_capture", out8, 8'h66);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) if (k != 5) d8[k] = ~d8[k];
      @(posedge clk); #1;
      check_val("iso_hold", out8, 8'h66);
      check_val("iso_valid", {7'd0, v8}, 8'h01);
    end

    // ---------------- Enable hold: capture C=8'hA5 then EN=0 for 3 cycles
    @(negedge clk);
    set_d8_ramp();
    d8[2] = 8'hA5;
    sel   = 3'd2;
    en    = 1'b1;
    @(posedge clk); #1;
    check_val("hold_capture", out8, 8'hA5);
    check_val("hold_cap_valid", {7'd0, v8}, 8'h01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      en  = 1'b0;
      sel = 3'(c + 4);
      for (int k = 0; k < 8; k++) d8[k] = 8'h3C ^ 8'(c * 17 + k);
      @(posedge clk); #1;
      check_val("hold_out", out8, 8'hA5);
      check_val("hold_valid", {7'd0, v8}, 8'h00);
    end

    // ---------------- Mid-stream reset with SEL cycling 0..7
    @(negedge clk);
    set_d8_ramp();
    en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      sel = 3'(j);
      @(posedge clk); #1;
      check_val("mid_out", out8, ramp_exp(3'(j)));
      check_val("mid_valid", {7'd0, v8}, 8'h01);
      if (j == 3) begin
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_out", out8, 8'h00);
        check_val("mid_rst_valid", {7'd0, v8}, 8'h00);
        rst_n = 1'b1;
        #1;
        check_val("mid_rel_out", out8, 8'h00);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dmux_8way
`default_nettype wire

// File: doc/dmux_8way.md
# dmux_8way

Registered 8-to-1 selector: one of eight equal-width data inputs (A–H) is chosen by a 3-bit select code and driven, one clock later, on OUT. Despite the historical "dmux" name, this is a many-to-one multiplexer, not a demultiplexer. It serves as a generic datapath steering element wherever a registered, enable-gated 8-way choice is needed.

## Interface
Parameters:
- WIDTH, default 1, bit width of each data input and of OUT (must be ≥ 1).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- EN  input  1  capture enable; when high, the selected input is registered this edge.
- A  input  WIDTH  data input, selected by SEL = 3'b000.
- B  input  WIDTH  data input, SEL = 3'b001.
- C  input  WIDTH  data input, SEL = 3'b010.
- D  input  WIDTH  data input, SEL = 3'b011.
- E  input  WIDTH  data input, SEL = 3'b100.
- F  input  WIDTH  data input, SEL = 3'b101.
- G  input  WIDTH  data input, SEL = 3'b110.
- H  input  WIDTH  data input, SEL = 3'b111.
- SEL  input  3  select code, binary index into A..H.
- OUT  output  WIDTH  registered selected data.
- VALID  output  1  high for the cycle after a capture (registered copy of EN).

## Operation
- Selection is a pure function of SEL: 0→A, 1→B, 2→C, 3→D, 4→E, 5→F, 6→G, 7→H. All eight codes are legal; there is no default or error case.
- On a rising CLK edge with RST_N high:
  - EN=1: OUT ← selected input, VALID ← 1.
  - EN=0: OUT holds its previous value, VALID ← 0.
- Non-selected inputs have no effect on OUT. Toggling them never changes OUT.
- Bits are selected bitwise-independently per WIDTH. There is no arithmetic, sign handling or truncation.
- No handshake back-pressure: every enabled cycle produces a result; the consumer samples OUT when VALID=1.

## Timing
- Latency: exactly 1 cycle from a capture edge (EN=1) to OUT/VALID update. No combinational path from any input to OUT or VALID.
- Reset: RST_N low forces OUT = {WIDTH{1'b0}} and VALID = 0 immediately, with no clock required. These values are held while reset is asserted.
- Reset release: the first rising edge with RST_N high behaves normally. An EN=1 on that edge captures.
- Reset mid-stream: any capture in flight is discarded. The post-reset OUT is 0 until the next enabled edge.
- Back-to-back EN=1 with changing SEL: OUT tracks the new selection every cycle, with no bubble.
- SEL and data changes between edges are irrelevant; only the values at the rising edge matter.

## Structure
- Shared package dmux_8way_pkg:
  - typedef sel_t = logic [2:0].
  - localparams SEL_A..SEL_H = 3'd0..3'd7, so the codebase refers to inputs symbolically.
- One natural sub-module: dmux_8way_sel, a purely combinational WIDTH-parameterized 8:1 selector (case on SEL).
  - The top level instantiates it and adds the OUT/VALID registers with the asynchronous active-low reset and EN hold logic.
- Bench: a self-checking reference model computing the expected OUT from {A..H, SEL} and comparing one cycle after each EN=1 edge.

## Test plan
- Reset: hold RST_N=0 with A..H=1, SEL=0, EN=1 → OUT=0 and VALID=0 asynchronously, before any clock edge. Release RST_N → the first edge gives OUT=1, VALID=1.
- Exhaustive sweep (WIDTH=1): drive {A,B,C,D,E,F,G,H,SEL} = i for i = 0..2047, EN=1, one vector per cycle → OUT = the input indexed by SEL on the next cycle in every case. Example: i=11'b10000000_000 → OUT=1; i=11'b10000000_001 → OUT=0.
- Isolation (WIDTH=8): A..H = 8'h11..8'h88, SEL=5 → OUT=8'h66. Toggle all inputs except F each cycle → OUT stays 8'h66.
- Enable hold: capture SEL=2 with C=8'hA5, then EN=0 for 3 cycles while SEL and data change → OUT stays 8'hA5 and VALID=0 for those cycles.
- Mid-stream reset: EN=1 with SEL cycling 0..7. Pulse RST_N low between edges → OUT and VALID drop to 0 immediately. After release, the next enabled edge resumes correct selection.
